// File: rtl/alu_pkg.sv
// Shared widths, opcode constants and the command record for the alu dispatch stage.
package alu_pkg;
  localparam int WORD_W = 32;
  localparam int OP_W   = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [OP_W-1:0]   op_t;

  // Only ADD is named here; the dispatcher forwards every opcode untouched.
  localparam op_t OP_ADD = 3'b000;

  typedef struct packed {
    word_t a;
    word_t b;
    op_t   op;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/alu_dispatch_if.sv
// Command and result valid/ready channels of alu_dispatch.
// Tag signals exist only when ALU_DISPATCH_TAG_EN is defined.
interface alu_dispatch_if
`ifdef ALU_DISPATCH_TAG_EN
  #(parameter int TAG_W = 4)
`endif
  ;
  import alu_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_a;
  word_t in_b;
  op_t   in_op;
  logic  out_valid;
  logic  out_ready;
  word_t out_data;
`ifdef ALU_DISPATCH_TAG_EN
  logic [TAG_W-1:0] in_tag;
  logic [TAG_W-1:0] out_tag;

  modport master (output in_valid, in_a, in_b, in_op, in_tag, out_ready,
                  input  in_ready, out_valid, out_data, out_tag);
  modport slave  (input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
                  output in_ready, out_valid, out_data, out_tag);
`else
  modport master (output in_valid, in_a, in_b, in_op, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_a, in_b, in_op, out_ready,
                  output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/alu_dispatch_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head reads as zero while empty.
module alu_dispatch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [W-1:0]                 wr_data_i,
  input  logic                         rd_en_i,
  output logic [W-1:0]                 rd_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  // Wrap explicitly so depths that are not a power of two work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/alu_dispatch.sv
// Issue/return wrapper around the fixed-latency, non-stallable alu core.
// Define ALU_DISPATCH_TAG_EN to carry a per-command tag through to the result.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int CDEPTH  = 4,
  parameter int RDEPTH  = 4,
  parameter int ALU_LAT = 2,
  parameter int TAG_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_dispatch_if.slave bus,
  output word_t         alu_a,
  output word_t         alu_b,
  output op_t           alu_op,
  input  word_t         alu_o
);
  localparam int CCNT_W = $clog2(CDEPTH + 1);
  localparam int RCNT_W = $clog2(RDEPTH + 1);
  localparam int INF_W  = $clog2(ALU_LAT + 1);
`ifdef ALU_DISPATCH_TAG_EN
  localparam int CE_W = CMD_W + TAG_W;
  localparam int RE_W = WORD_W + TAG_W;
`else
  localparam int CE_W = CMD_W;
  localparam int RE_W = WORD_W;
`endif
  localparam cmd_t ALU_RST = '{a: '0, b: '0, op: OP_ADD};

  logic [CE_W-1:0]    cmd_wr, cmd_rd;
  logic               cmd_full, cmd_empty, cmd_push;
  logic [CCNT_W-1:0]  cmd_count;
  logic [RE_W-1:0]    res_wr, res_rd;
  logic               res_full, res_empty, res_pop;
  logic [RCNT_W-1:0]  res_count;
  cmd_t               cmd_head, alu_q, alu_d;
  logic               issue, capture;
  logic [ALU_LAT-1:0] vpipe_q, vpipe_d;
  logic [INF_W-1:0]   inflight_q, inflight_d;
  logic               unused_ok;

  assign bus.in_ready = !cmd_full && !rst;
  assign cmd_push     = bus.in_valid && bus.in_ready;
  assign cmd_head     = cmd_rd[CMD_W-1:0];

  // Credit check uses pre-edge counts, so every in-flight op owns a result slot.
  assign issue      = !cmd_empty && (int'(inflight_q) + int'(res_count) < RDEPTH);
  assign capture    = vpipe_q[ALU_LAT-1];
  assign inflight_d = inflight_q + INF_W'(issue) - INF_W'(capture);
  assign alu_d      = issue ? cmd_head : alu_q;

  assign vpipe_d[0] = issue;
  for (genvar gi = 1; gi < ALU_LAT; gi++) begin : g_vpipe
    assign vpipe_d[gi] = vpipe_q[gi-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q    <= '0;
      inflight_q <= '0;
      alu_q      <= ALU_RST;
    end else begin
      vpipe_q    <= vpipe_d;
      inflight_q <= inflight_d;
      alu_q      <= alu_d;
    end
  end

  assign alu_a  = alu_q.a;
  assign alu_b  = alu_q.b;
  assign alu_op = alu_q.op;

`ifdef ALU_DISPATCH_TAG_EN
  logic [ALU_LAT-1:0][TAG_W-1:0] tpipe_q, tpipe_d;

  assign cmd_wr     = {bus.in_tag, bus.in_a, bus.in_b, bus.in_op};
  assign tpipe_d[0] = cmd_rd[CMD_W +: TAG_W];
  for (genvar gi = 1; gi < ALU_LAT; gi++) begin : g_tpipe
    assign tpipe_d[gi] = tpipe_q[gi-1];
  end

  always_ff @(posedge clk) begin
    if (rst) tpipe_q <= '0;
    else     tpipe_q <= tpipe_d;
  end

  assign res_wr      = {tpipe_q[ALU_LAT-1], alu_o};
  assign bus.out_tag = res_rd[WORD_W +: TAG_W];
`else
  assign cmd_wr = {bus.in_a, bus.in_b, bus.in_op};
  assign res_wr = alu_o;
`endif

  assign res_pop       = bus.out_valid && bus.out_ready;
  assign bus.out_valid = !res_empty;
  assign bus.out_data  = res_rd[WORD_W-1:0];

  alu_dispatch_fifo #(.W(CE_W), .DEPTH(CDEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (cmd_push),
    .wr_data_i (cmd_wr),
    .rd_en_i   (issue),
    .rd_data_o (cmd_rd),
    .full_o    (cmd_full),
    .empty_o   (cmd_empty),
    .count_o   (cmd_count)
  );

  alu_dispatch_fifo #(.W(RE_W), .DEPTH(RDEPTH)) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (capture),
    .wr_data_i (res_wr),
    .rd_en_i   (res_pop),
    .rd_data_o (res_rd),
    .full_o    (res_full),
    .empty_o   (res_empty),
    .count_o   (res_count)
  );

  assign unused_ok = ^{cmd_count, res_full, (TAG_W > 0)};
endmodule
